// File: rtl/ram8_clear_16bit_pkg.sv
// Types and constants shared by the ram8_clear_16bit block and its read mux.
// Values come from ram8_defs.vh so every level of the RAM hierarchy agrees.
`include "ram8_defs.vh"

package ram8_clear_16bit_pkg;

    localparam int RAM8_WIDTH_C = `RAM8_WIDTH;
    localparam int RAM8_DEPTH_C = `RAM8_DEPTH;
    localparam logic [2:0] RAM8_CLR_LAST_C = `RAM8_CLR_LAST;

    typedef enum logic {
        ST_IDLE = `RAM8_ST_IDLE,
        ST_CLR  = `RAM8_ST_CLR
    } ram8_state_e;

endpackage

// File: rtl/ram8_clear_16bit_mux.sv
// 8-way, 16-bit combinational read multiplexer (Mux8way16bit) used as the
// read path of the RAM8 storage stage.
module Mux8way16bit (
    input  logic [15:0] in0,
    input  logic [15:0] in1,
    input  logic [15:0] in2,
    input  logic [15:0] in3,
    input  logic [15:0] in4,
    input  logic [15:0] in5,
    input  logic [15:0] in6,
    input  logic [15:0] in7,
    input  logic [2:0]  sel,
    output logic [15:0] out
);

    always_comb begin
        out = in0;
        case (sel)
            3'd0: out = in0;
            3'd1: out = in1;
            3'd2: out = in2;
            3'd3: out = in3;
            3'd4: out = in4;
            3'd5: out = in5;
            3'd6: out = in6;
            3'd7: out = in7;
            default: out = in0;
        endcase
    end

endmodule

// File: rtl/ram8_defs.vh
// Shared constants for the RAM8 storage stage: state encodings, geometry and
// the last clear index.
`ifndef RAM8_DEFS_VH
`define RAM8_DEFS_VH

`define RAM8_ST_IDLE  1'b0
`define RAM8_ST_CLR   1'b1
`define RAM8_WIDTH    16
`define RAM8_DEPTH    8
`define RAM8_CLR_LAST 3'd7

`endif

// File: rtl/ram8_clear_16bit.sv
// Eight-word x 16-bit register bank with combinational read and a bulk-clear
// sequencer; optional per-word parity when RAM8_PARITY_EN is defined.
module ram8_clear_16bit
    import ram8_clear_16bit_pkg::*;
#(
    parameter int WIDTH = RAM8_WIDTH_C,
    parameter int DEPTH = RAM8_DEPTH_C
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in,
    input  logic        load,
    input  logic [2:0]  address,
    input  logic        clear,
`ifdef RAM8_PARITY_EN
    input  logic        parity_inject,
    output logic        parity_err,
`endif
    output logic [15:0] out,
    output logic        busy
);

    ram8_state_e      state_q, state_d;
    logic [2:0]       clr_ptr_q, clr_ptr_d;
    logic [WIDTH-1:0] words_q [DEPTH];
    logic [WIDTH-1:0] words_d [DEPTH];
`ifdef RAM8_PARITY_EN
    logic [DEPTH-1:0] par_q, par_d;
`endif

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        words_d   = words_q;
`ifdef RAM8_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // A load on the same edge as clear still lands; the sweep
                // zeroes it later.
                if (load) begin
                    words_d[address] = in;
`ifdef RAM8_PARITY_EN
                    par_d[address] = (^in) ^ parity_inject;
`endif
                end
                if (clear) begin
                    state_d   = ST_CLR;
                    clr_ptr_d = 3'd0;
                end
            end
            ST_CLR: begin
                words_d[clr_ptr_q] = '0;
`ifdef RAM8_PARITY_EN
                par_d[clr_ptr_q] = 1'b0;
`endif
                clr_ptr_d = clr_ptr_q + 3'd1;
                if (clr_ptr_q == RAM8_CLR_LAST_C) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                clr_ptr_d = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            clr_ptr_q <= 3'd0;
            for (int i = 0; i < DEPTH; i++) begin
                words_q[i] <= '0;
            end
`ifdef RAM8_PARITY_EN
            par_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            words_q   <= words_d;
`ifdef RAM8_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign busy = (state_q == ST_CLR);

    Mux8way16bit u_mux (
        .in0 (words_q[0]),
        .in1 (words_q[1]),
        .in2 (words_q[2]),
        .in3 (words_q[3]),
        .in4 (words_q[4]),
        .in5 (words_q[5]),
        .in6 (words_q[6]),
        .in7 (words_q[7]),
        .sel (address),
        .out (out)
    );

`ifdef RAM8_PARITY_EN
    assign parity_err = (^words_q[address]) ^ par_q[address];
`endif

endmodule
